// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with OVERSAMPLE-times oversampling and 2-of-3 mid-bit voting.
// Latency: rx_valid about 9.5 bit times after the start edge, plus 2 clk synchroniser and 1 clk output register.
// Backpressure: none; rx_valid / frame_err are single-cycle strobes and must be consumed when they appear.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high, priority over everything
//   rx         raw serial line, asynchronous, idle high
//   rx_data    last correctly framed byte, held until the next valid byte
//   rx_valid   one-cycle strobe: rx_data updated this cycle
//   frame_err  one-cycle strobe: stop bit sampled low
//   busy       high from start-edge detection until the FSM returns to IDLE
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_n;

  logic                 rx_meta, rx_s, rx_prev;
  logic                 fall;
  logic                 counting;
  logic [PW-1:0]        prescaler;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 tick, wrap, decide;
  logic                 v0, v1, vote;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 set_valid, set_err, shift_en;

  // Two-flop synchroniser; resets to the idle level so reset never fakes a start edge.
  // rx_prev holds the previous synchronised value for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  // Counters only run while a frame is being sampled; holding them at zero
  // otherwise phase-aligns the first tick to the detected start edge.
  assign counting = (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign tick     = counting && (prescaler == PW'(DIV - 1));
  assign wrap     = tick && (sample_cnt == SW'(OVERSAMPLE - 1));
  assign decide   = tick && (sample_cnt == SW'(M + 1));

  always_ff @(posedge clk) begin
    if (rst || !counting) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !counting) begin
      sample_cnt <= '0;
    end else if (wrap) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= sample_cnt + SW'(1);
    end
  end

  // First two votes are captured at the ticks ending samples M-1 and M; the
  // third is rx_s itself at the tick ending sample M+1, where the decision is made.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      if (tick && (sample_cnt == SW'(M - 1))) v0 <= rx_s;
      if (tick && (sample_cnt == SW'(M)))     v1 <= rx_s;
    end
  end

  assign vote = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    set_valid = 1'b0;
    set_err   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) state_n = S_START;
      end
      S_START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (decide && vote) begin
          state_n = S_IDLE;
        end else if (wrap) begin
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        shift_en = decide;
        if (wrap && (bit_idx == BW'(DATA_BITS - 1))) state_n = S_STOP;
      end
      S_STOP: begin
        // Leave at the mid-bit decision so a start edge right at the end of
        // the stop bit is still caught by the IDLE edge detector.
        if (decide) begin
          if (vote) begin
            set_valid = 1'b1;
            state_n   = S_IDLE;
          end else begin
            set_err   = 1'b1;
            state_n   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so a break reports only one error.
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (state != S_DATA)) begin
      bit_idx <= '0;
    end else if (wrap) begin
      if (bit_idx == BW'(DATA_BITS - 1)) begin
        bit_idx <= '0;
      end else begin
        bit_idx <= bit_idx + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < DATA_BITS; i++) begin
        if (bit_idx == BW'(i)) shift_reg[i] <= vote;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= set_valid;
      frame_err <= set_err;
      if (set_valid) rx_data <= shift_reg;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
